// File: rtl/prd_bus_pkg.sv
// Shared types and default constants for the PRD board bus sequencer.
package prd_bus_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} busState_t;
  typedef enum logic {HOST, POLL} requester_t;

  localparam logic [3:0] CS_DEFAULT          = 4'b1011;
  localparam logic [3:0] CS_IDLE             = 4'b0000;
  localparam int         T_SETUP_DEFAULT     = 1;
  localparam int         T_STROBE_DEFAULT    = 2;
  localparam int         T_HOLD_DEFAULT      = 1;
  localparam int         POLL_PERIOD_DEFAULT = 1000;
  localparam logic [1:0] POLL_ADDR_DEFAULT   = 2'b01;

  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/prd_poll_timer.sv
// Free-running poll reload timer with a saturating pending flag.
module prd_poll_timer
  import prd_bus_pkg::*;
#(
  parameter int POLL_PERIOD = POLL_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic iRes,
  input  logic iClr,
  output logic oPending
);

  localparam int            W      = cntWidth(POLL_PERIOD - 1);
  localparam logic [W-1:0]  RELOAD = W'(POLL_PERIOD - 1);

  logic [W-1:0] count;

  // A clear only arrives while pending is set, so an expiry on that edge is
  // an expiry-while-pending and is dropped.
  always_ff @(posedge clk) begin
    if (!iRes) begin
      count    <= RELOAD;
      oPending <= 1'b0;
    end else begin
      if (count == '0) count <= RELOAD;
      else             count <= count - 1'b1;
      if (iClr)               oPending <= 1'b0;
      else if (count == '0)   oPending <= 1'b1;
    end
  end

endmodule

// File: rtl/prd_bus_sequencer.sv
// PRD board bus master: arbitrates host vs. command poller and runs timed cycles.
// Optional change interrupt on polled data is built when PRD_POLL_CHANGE_IRQ_EN is defined.
//
// state  | meaning
// IDLE   | bus released, arbitration open (when iBl=1)
// SETUP  | CS/address (and write data) valid, strobes high
// STROBE | oRd or oWr low; read data sampled on the last cycle
// HOLD   | strobes high, CS/address/data still held
module prd_bus_sequencer
  import prd_bus_pkg::*;
#(
  parameter logic [3:0] CS          = CS_DEFAULT,
  parameter int         T_SETUP     = T_SETUP_DEFAULT,
  parameter int         T_STROBE    = T_STROBE_DEFAULT,
  parameter int         T_HOLD      = T_HOLD_DEFAULT,
  parameter int         POLL_PERIOD = POLL_PERIOD_DEFAULT,
  parameter logic [1:0] POLL_ADDR   = POLL_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        iRes,
  input  logic        iBl,
  input  logic        iHostReq,
  input  logic        iHostWe,
  input  logic [1:0]  iHostA,
  input  logic [15:0] iHostWData,
  output logic        oHostAck,
  output logic [15:0] oHostRData,
  output logic [15:0] oComState,
  output logic        oComValid,
  output logic        oComIrq,
  output logic [3:0]  oCS,
  output logic [1:0]  oA,
  output logic        oRd,
  output logic        oWr,
  inout  wire  [15:0] bD
);

  localparam int TMAX = (T_SETUP > T_STROBE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                             : ((T_STROBE > T_HOLD) ? T_STROBE : T_HOLD);
  localparam int             PW          = cntWidth(TMAX);
  localparam logic [PW-1:0]  SETUP_LOAD  = PW'(T_SETUP - 1);
  localparam logic [PW-1:0]  STROBE_LOAD = PW'(T_STROBE - 1);
  localparam logic [PW-1:0]  HOLD_LOAD   = PW'(T_HOLD - 1);

  busState_t   state;
  requester_t  curReq, lastGrant;
  logic [PW-1:0] phaseCnt;
  logic        curWe, driveEn, pollPending;
  logic [15:0] wData, rdData;
  logic        hostWants, grantHost, grantPoll;

  prd_poll_timer #(.POLL_PERIOD(POLL_PERIOD)) uPollTimer (
    .clk      (clk),
    .iRes     (iRes),
    .iClr     (grantPoll),
    .oPending (pollPending)
  );

  // The host still holds its request during the ack cycle; don't re-grant it there.
  assign hostWants = iHostReq & ~oHostAck;

  always_comb begin
    grantHost = 1'b0;
    grantPoll = 1'b0;
    if (state == IDLE && iBl) begin
      if (hostWants && pollPending) begin
        grantHost = (lastGrant == POLL);
        grantPoll = (lastGrant == HOST);
      end else begin
        grantHost = hostWants;
        grantPoll = pollPending;
      end
    end
  end

  assign bD = driveEn ? wData : 16'hzzzz;

  always_ff @(posedge clk) begin
    if (!iRes) begin
      state      <= IDLE;
      curReq     <= POLL;
      lastGrant  <= POLL;
      phaseCnt   <= '0;
      curWe      <= 1'b0;
      driveEn    <= 1'b0;
      wData      <= '0;
      rdData     <= '0;
      oCS        <= CS_IDLE;
      oA         <= 2'b00;
      oRd        <= 1'b1;
      oWr        <= 1'b1;
      oHostAck   <= 1'b0;
      oHostRData <= '0;
      oComState  <= '0;
      oComValid  <= 1'b0;
`ifdef PRD_POLL_CHANGE_IRQ_EN
      oComIrq    <= 1'b0;
`endif
    end else begin
      oHostAck  <= 1'b0;
      oComValid <= 1'b0;
`ifdef PRD_POLL_CHANGE_IRQ_EN
      oComIrq   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grantHost || grantPoll) begin
            state     <= SETUP;
            phaseCnt  <= SETUP_LOAD;
            curReq    <= grantHost ? HOST : POLL;
            lastGrant <= grantHost ? HOST : POLL;
            curWe     <= grantHost & iHostWe;
            driveEn   <= grantHost & iHostWe;
            wData     <= iHostWData;
            oCS       <= CS;
            oA        <= grantHost ? iHostA : POLL_ADDR;
          end
        end
        SETUP: begin
          if (phaseCnt == '0) begin
            state    <= STROBE;
            phaseCnt <= STROBE_LOAD;
            oRd      <= curWe;
            oWr      <= ~curWe;
          end else begin
            phaseCnt <= phaseCnt - 1'b1;
          end
        end
        STROBE: begin
          if (phaseCnt == '0) begin
            state    <= HOLD;
            phaseCnt <= HOLD_LOAD;
            oRd      <= 1'b1;
            oWr      <= 1'b1;
            rdData   <= bD;
          end else begin
            phaseCnt <= phaseCnt - 1'b1;
          end
        end
        HOLD: begin
          if (phaseCnt == '0) begin
            state   <= IDLE;
            oCS     <= CS_IDLE;
            oA      <= 2'b00;
            driveEn <= 1'b0;
            if (curReq == HOST) begin
              oHostAck <= 1'b1;
              if (!curWe) oHostRData <= rdData;
            end else begin
              oComValid <= 1'b1;
              oComState <= rdData;
`ifdef PRD_POLL_CHANGE_IRQ_EN
              oComIrq   <= (rdData != oComState);
`endif
            end
          end else begin
            phaseCnt <= phaseCnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef PRD_POLL_CHANGE_IRQ_EN
  assign oComIrq = 1'b0;
`endif

endmodule

// File: tb/tb_prd_bus_sequencer.sv
// Self-checking bench for prd_bus_sequencer with a board model (register file
// plus read-only command register) and a transaction-level reference memory.
module tb_prd_bus_sequencer;

  localparam logic [3:0] CS_CODE = 4'b1011;
  localparam logic [1:0] POLL_A  = 2'b01;

  logic        clk;
  logic        iRes, iBl, iHostReq, iHostWe;
  logic [1:0]  iHostA;
  logic [15:0] iHostWData;
  logic        oHostAck, oComValid, oComIrq, oRd, oWr;
  logic [15:0] oHostRData, oComState;
  logic [3:0]  oCS;
  logic [1:0]  oA;
  wire  [15:0] bD;

  prd_bus_sequencer #(.POLL_PERIOD(8)) dut (
    .clk(clk), .iRes(iRes), .iBl(iBl), .iHostReq(iHostReq), .iHostWe(iHostWe),
    .iHostA(iHostA), .iHostWData(iHostWData), .oHostAck(oHostAck), .oHostRData(oHostRData),
    .oComState(oComState), .oComValid(oComValid), .oComIrq(oComIrq), .oCS(oCS), .oA(oA),
    .oRd(oRd), .oWr(oWr), .bD(bD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board: drives on read strobe; the probe drives 0 so a leaking DUT driver shows up.
  logic [15:0] boardMem [4];
  logic [15:0] cmdReg;
  logic        probeEn;
  assign bD = (!oRd) ? ((oA == POLL_A) ? cmdReg : boardMem[oA]) : (probeEn ? 16'h0000 : 16'hzzzz);

  always @(posedge clk) begin
    if (!iRes) begin
      boardMem[0] <= 16'h0000; boardMem[1] <= 16'h0000;
      boardMem[2] <= 16'h0000; boardMem[3] <= 16'h0025;
    end else if (!oWr) begin
      boardMem[oA] <= bD;
    end
  end

  // Strobe-width monitor
  int runLen = 0, runs = 0, badRuns = 0;
  always @(negedge clk) begin
    if (!iRes) runLen = 0;
    else if (!oRd && !oWr) begin badRuns++; runLen = 0; end
    else if (!oRd || !oWr) runLen++;
    else if (runLen != 0) begin runs++; if (runLen != 2) badRuns++; runLen = 0; end
  end

  int tests = 0, fails = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [15:0] refMem [4];

  task automatic resetDut();
    @(negedge clk);
    iRes = 1'b0; iHostReq = 1'b0;
    repeat (3) @(negedge clk);
    iRes = 1'b1;
    refMem[0] = 16'h0000; refMem[1] = 16'h0000; refMem[2] = 16'h0000; refMem[3] = 16'h0025;
  endtask

  logic [15:0] xRd;
  int          xBusy, xRdLow, xWrLow, xBdBad, xGap;
  logic        xAcked;

  task automatic hostXfer(input logic we, input logic [1:0] a, input logic [15:0] wd);
    int lastBusy;
    iHostReq = 1'b1; iHostWe = we; iHostA = a; iHostWData = wd;
    xRd = '0; xBusy = 0; xRdLow = 0; xWrLow = 0; xBdBad = 0; xGap = 0; xAcked = 1'b0;
    lastBusy = 0;
    for (int c = 1; c <= 80 && !xAcked; c++) begin
      @(negedge clk);
      if (oHostAck) begin
        xAcked = 1'b1; xRd = oHostRData; xGap = c - lastBusy;
      end else if (oCS != 4'b0000 && oA == a) begin
        xBusy++; lastBusy = c;
        if (!oRd) xRdLow++;
        if (!oWr) xWrLow++;
        if (we && bD !== wd) xBdBad++;
        if (xBusy == 1) begin iHostWe = ~we; iHostA = a ^ 2'b10; iHostWData = ~wd; end
      end
    end
    iHostReq = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  a;
    logic [15:0] wd;
    logic [15:0] expRd;
  } vec_t;
  vec_t vecs [7];

  int valids, firstValid, lastValid, badInterval, badState, badA, seen, irqs, irqNoValid;
  logic expIrq;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef PRD_POLL_CHANGE_IRQ_EN
    expIrq = 1'b1;
`else
    expIrq = 1'b0;
`endif
    iRes = 1'b0; iBl = 1'b1; iHostReq = 1'b0; iHostWe = 1'b0; iHostA = 2'b00;
    iHostWData = 16'h0; probeEn = 1'b0; cmdReg = 16'hAA55;

    vecs[0] = '{1'b0, 2'd3, 16'h0000, 16'h0025};
    vecs[1] = '{1'b1, 2'd2, 16'hA4A4, 16'h0000};
    vecs[2] = '{1'b0, 2'd2, 16'h0000, 16'hA4A4};
    vecs[3] = '{1'b1, 2'd0, 16'h5A0F, 16'h0000};
    vecs[4] = '{1'b0, 2'd0, 16'h0000, 16'h5A0F};
    vecs[5] = '{1'b1, 2'd3, 16'h1234, 16'h0000};
    vecs[6] = '{1'b0, 2'd3, 16'h0000, 16'h1234};

    // Reset values
    resetDut();
    check("rst oCS", oCS, 4'b0000);
    check("rst strobes", {oRd, oWr}, 2'b11);
    check("rst pulses", {oHostAck, oComValid, oComIrq}, 3'b000);
    check("rst oHostRData", oHostRData, 16'h0);
    check("rst oComState", oComState, 16'h0);

    // Reset in the middle of a host write
    iHostReq = 1'b1; iHostWe = 1'b1; iHostA = 2'd2; iHostWData = 16'hA4A4;
    for (int c = 0; c < 5 && oCS == 4'b0000; c++) @(negedge clk);
    @(negedge clk);
    check("midwr strobe active", oWr, 1'b0);
    iRes = 1'b0; iHostReq = 1'b0; probeEn = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (oCS != 4'b0000 || !oRd || !oWr || bD !== 16'h0000 || oHostAck) seen++;
    end
    check("midwr reset bus idle", seen, 0);
    iRes = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (oHostAck) seen++;
    end
    probeEn = 1'b0;
    check("midwr no ack", seen, 0);
    check("midwr no rdata", oHostRData, 16'h0);

    // Poll cadence with no host traffic
    resetDut();
    valids = 0; firstValid = 0; lastValid = 0; badInterval = 0; badState = 0; badA = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (oCS != 4'b0000 && (oA != POLL_A || oCS != CS_CODE)) badA++;
      if (oComValid) begin
        valids++;
        if (valids == 1) firstValid = c;
        else if (c - lastValid != 8) badInterval++;
        lastValid = c;
        if (oComState != 16'hAA55) badState++;
      end
    end
    check("poll first valid cycle", firstValid, 13);
    check("poll valid count", valids, 5);
    check("poll interval", badInterval, 0);
    check("poll data", badState, 0);
    check("poll addr/cs", badA, 0);

    // Host request and poll expiry arriving together: host first, then poll
    resetDut();
    repeat (8) @(negedge clk);
    check("arb idle before expiry", oCS, 4'b0000);
    iHostReq = 1'b1; iHostWe = 1'b0; iHostA = 2'd3; iHostWData = 16'h0;
    @(negedge clk);
    check("arb host granted first", {oCS, oA}, {CS_CODE, 2'd3});
    hostXfer(1'b0, 2'd3, 16'h0);
    check("arb host ack", xAcked, 1'b1);
    check("arb host rdata", xRd, 16'h0025);
    check("arb host busy rest", xBusy, 3);
    @(negedge clk);
    check("arb poll next", {oCS, oA}, {CS_CODE, POLL_A});

    // Table-driven host transfers
    foreach (vecs[i]) begin
      hostXfer(vecs[i].we, vecs[i].a, vecs[i].wd);
      check($sformatf("vec%0d ack", i), xAcked, 1'b1);
      check($sformatf("vec%0d busy", i), xBusy, 4);
      check($sformatf("vec%0d ack gap", i), xGap, 1);
      check($sformatf("vec%0d rd low", i), xRdLow, vecs[i].we ? 0 : 2);
      check($sformatf("vec%0d wr low", i), xWrLow, vecs[i].we ? 2 : 0);
      if (vecs[i].we) begin
        check($sformatf("vec%0d bD data", i), xBdBad, 0);
        probeEn = 1'b1;
        @(negedge clk);
        check($sformatf("vec%0d bD released", i), {16'h0, bD}, 32'h0);
        probeEn = 1'b0;
        refMem[vecs[i].a] = vecs[i].wd;
      end else begin
        check($sformatf("vec%0d rdata", i), xRd, vecs[i].expRd);
      end
    end

    // Block input holds off new grants
    for (int c = 0; c < 20 && oCS != 4'b0000; c++) @(negedge clk);
    iBl = 1'b0;
    iHostReq = 1'b1; iHostWe = 1'b0; iHostA = 2'd0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (oCS != 4'b0000) seen++;
    end
    check("iBl blocks grants", seen, 0);
    iBl = 1'b1;
    @(negedge clk);
    check("iBl release starts cycle", oCS, CS_CODE);
    hostXfer(1'b0, 2'd0, 16'h0);
    check("iBl host ack", xAcked, 1'b1);
    check("iBl host rdata", xRd, refMem[0]);

    // Change of polled value
    repeat (20) @(negedge clk);
    for (int c = 0; c < 10 && !oRd; c++) @(negedge clk);
    cmdReg = 16'h1111;
    irqs = 0; irqNoValid = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (oComIrq) irqs++;
      if (oComIrq && !oComValid) irqNoValid++;
    end
    check("irq pulse count", irqs, expIrq ? 1 : 0);
    check("irq only with valid", irqNoValid, 0);
    check("polled new value", oComState, 16'h1111);

    // Randomized host traffic against the reference memory
    resetDut();
    for (int i = 0; i < 30; i++) begin
      logic        w;
      logic [1:0]  a;
      logic [15:0] d;
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       a = 2'd0;
        1:       a = 2'd2;
        default: a = 2'd3;
      endcase
      d = 16'($urandom);
      hostXfer(w, a, d);
      check($sformatf("rnd%0d ack", i), xAcked, 1'b1);
      check($sformatf("rnd%0d busy", i), xBusy, 4);
      if (w) refMem[a] = d;
      else   check($sformatf("rnd%0d rdata", i), xRd, refMem[a]);
      if ($urandom_range(0, 1) == 1) begin
        iBl = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        iBl = 1'b1;
      end
    end

    check("strobe widths", badRuns, 0);
    check("strobe runs seen", (runs > 20) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
